game_turn_sequencer: RTL and testbench

- Central controller for the two-player lane-crossing VGA game.
- Owns the game state (QI / QGAME_1 / QGAME_2 / QDONE), the active player's lane row, both scores and the per-turn timer.
- Sequences the obstacle-lane datapath with shift and clear strobes, and consumes the collision checker's hit flag.
- Sits between the button/divider logic and the VGA renderer, LEDs and SSD.

---
 rtl/game_pkg.sv | 59 +++++
 rtl/game_turn_timer.sv | 45 ++++
 rtl/game_turn_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_game_turn_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
//   Shared types and constants for the lane-crossing game controller.
//
//   Contents:
//     - game_state_e  : top-level game state, encoded for the state output
//     - tick_action_e : what a game tick resolves to in the sequencer
//     - row_t/score_t : lane row index and player score types
//     - START_ROW, GOAL_ROW, WIN_SCORE
//     - next_row()    : applies one up/down move with the bottom-row clamp
// -----------------------------------------------------------------------------
package game_pkg;

  localparam int NUM_ROWS = 8;
  localparam int ROW_W    = $clog2(NUM_ROWS);
  localparam int SCORE_W  = 4;

  typedef logic [ROW_W-1:0]   row_t;
  typedef logic [SCORE_W-1:0] score_t;

  // Every turn begins on the bottom row; reaching the top row scores.
  localparam row_t   START_ROW = row_t'(NUM_ROWS - 1);
  localparam row_t   GOAL_ROW  = row_t'(0);
  localparam score_t WIN_SCORE = score_t'(10);

  typedef enum logic [1:0] {
    QI      = 2'b00,
    QGAME_1 = 2'b01,
    QGAME_2 = 2'b10,
    QDONE   = 2'b11
  } game_state_e;

  // Resolution of one tick inside a game state, in priority order:
  // a hit ends the turn, a goal scores (possibly winning), an expired
  // timer ends the turn, otherwise the move is simply applied.
  typedef enum logic [2:0] {
    ACT_IDLE,
    ACT_MOVE,
    ACT_GOAL,
    ACT_WIN,
    ACT_END_TURN
  } tick_action_e;

  // Up moves toward GOAL_ROW (row - 1); down moves toward START_ROW and
  // stops there. Up and down together cancel. An up move from GOAL_ROW
  // never happens: the sequencer resets the row as soon as it is reached.
  function automatic row_t next_row(input row_t row, input logic up,
                                    input logic dn);
    row_t r;
    r = row;
    if (up && !dn) begin
      r = row - row_t'(1);
    end else if (dn && !up && (row < START_ROW)) begin
      r = row + row_t'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/game_turn_timer.sv
// -----------------------------------------------------------------------------
// game_turn_timer
//   Per-turn down-counter. Loads TURN_TICKS on load, decrements by one on
//   each enabled tick, and flags expired while the count is at its last
//   tick, so the tick that would take it to zero is the one that ends the
//   turn.
//
//   Ports:
//     clk      in   system clock
//     reset    in   synchronous active-low reset (count = TURN_TICKS)
//     load     in   reload the count to TURN_TICKS (wins over en)
//     en       in   decrement the count by one
//     expired  out  count is at its final tick (count <= 1)
// -----------------------------------------------------------------------------
module game_turn_timer #(
  parameter int TIMER_W    = 8,
  parameter int TURN_TICKS = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(TURN_TICKS);
  localparam logic [TIMER_W-1:0] ONE    = TIMER_W'(1);

  logic [TIMER_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= RELOAD;
    end else if (load) begin
      count <= RELOAD;
    end else if (en && (count != '0)) begin
      count <= count - ONE;
    end
  end

  assign expired = (count <= ONE);

endmodule

// File: rtl/game_turn_sequencer.sv
// -----------------------------------------------------------------------------
// game_turn_sequencer
//   Central controller of the two-player lane-crossing game. Owns the game
//   state, the active player's row, both scores and the per-turn timer, and
//   drives the obstacle-lane datapath with shift/clear strobes.
//
//   Ports:
//     clk         in   system clock (single domain)
//     reset       in   synchronous active-low reset
//     start       in   level: 1 = play, 0 = return to idle
//     tick        in   one-cycle game-step strobe
//     btn_up      in   one-cycle debounced up pulse
//     btn_down    in   one-cycle debounced down pulse
//     hit         in   collision flag for player_row, used only on tick
//     state       out  QI / QGAME_1 / QGAME_2 / QDONE
//     player_row  out  active player's lane row
//     lane_shift  out  one-cycle strobe: rotate obstacle rows
//     lane_clear  out  one-cycle strobe: reload lane patterns
//     p1_score    out  player 1 score
//     p2_score    out  player 2 score
//
//   All outputs are registered; strobes appear in the cycle after the edge
//   that decides them.
// -----------------------------------------------------------------------------
module game_turn_sequencer
  import game_pkg::*;
#(
  parameter int TURN_TICKS = 200,
  parameter int TIMER_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               tick,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               hit,
  output logic [1:0]         state,
  output logic [ROW_W-1:0]   player_row,
  output logic               lane_shift,
  output logic               lane_clear,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score
);

  game_state_e  state_q, state_nxt;
  tick_action_e action;

  row_t   row_nxt;
  row_t   row_moved;
  score_t p1_nxt, p2_nxt;
  score_t cur_score, score_inc;

  logic shift_nxt, clear_nxt;
  logic pend_up, pend_dn, pend_up_nxt, pend_dn_nxt;
  logic up_eff, dn_eff;
  logic in_game;
  logic timer_load, timer_en, timer_expired;

  assign state = state_q;

  // ---------------------------------------------------------------------------
  // Turn timer
  // ---------------------------------------------------------------------------
  game_turn_timer #(
    .TIMER_W    (TIMER_W),
    .TURN_TICKS (TURN_TICKS)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // ---------------------------------------------------------------------------
  // Tick decode
  // ---------------------------------------------------------------------------
  assign in_game = (state_q == QGAME_1) || (state_q == QGAME_2);

  // A pulse arriving in the same cycle as the tick still counts.
  assign up_eff    = pend_up | btn_up;
  assign dn_eff    = pend_dn | btn_down;
  assign row_moved = next_row(player_row, up_eff, dn_eff);

  assign cur_score = (state_q == QGAME_2) ? p2_score : p1_score;
  assign score_inc = (cur_score >= WIN_SCORE) ? WIN_SCORE
                                              : cur_score + score_t'(1);

  // NOTE: every variable written in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    action = ACT_IDLE;
    if (in_game && start && tick) begin
      if (hit) begin
        action = ACT_END_TURN;
      end else if (row_moved == GOAL_ROW) begin
        // A goal reloads the timer, so it beats a same-tick timeout.
        action = (score_inc == WIN_SCORE) ? ACT_WIN : ACT_GOAL;
      end else if (timer_expired) begin
        action = ACT_END_TURN;
      end else begin
        action = ACT_MOVE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State register and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= QI;
      player_row <= START_ROW;
      p1_score   <= '0;
      p2_score   <= '0;
      lane_shift <= 1'b0;
      lane_clear <= 1'b0;
      pend_up    <= 1'b0;
      pend_dn    <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      player_row <= row_nxt;
      p1_score   <= p1_nxt;
      p2_score   <= p2_nxt;
      lane_shift <= shift_nxt;
      lane_clear <= clear_nxt;
      pend_up    <= pend_up_nxt;
      pend_dn    <= pend_dn_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      QI: begin
        if (start) state_nxt = QGAME_1;
      end
      QGAME_1, QGAME_2: begin
        if (!start) begin
          state_nxt = QI;
        end else if (action == ACT_END_TURN) begin
          state_nxt = (state_q == QGAME_1) ? QGAME_2 : QGAME_1;
        end else if (action == ACT_WIN) begin
          state_nxt = QDONE;
        end
      end
      QDONE: begin
        if (!start) state_nxt = QI;
      end
      default: state_nxt = QI;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    row_nxt     = player_row;
    p1_nxt      = p1_score;
    p2_nxt      = p2_score;
    shift_nxt   = 1'b0;
    clear_nxt   = 1'b0;
    pend_up_nxt = pend_up;
    pend_dn_nxt = pend_dn;
    timer_load  = 1'b0;
    timer_en    = 1'b0;

    case (state_q)
      QI: begin
        // Idle: row parked at the bottom, button pulses discarded.
        row_nxt     = START_ROW;
        pend_up_nxt = 1'b0;
        pend_dn_nxt = 1'b0;
        if (start) begin
          p1_nxt     = '0;
          p2_nxt     = '0;
          timer_load = 1'b1;
          clear_nxt  = 1'b1;
        end
      end

      QGAME_1, QGAME_2: begin
        if (!start) begin
          // Abort: scores are kept for display until the next start.
          row_nxt     = START_ROW;
          pend_up_nxt = 1'b0;
          pend_dn_nxt = 1'b0;
        end else if (tick) begin
          // Every game tick shifts the lanes, including turn-ending ones.
          shift_nxt   = 1'b1;
          pend_up_nxt = 1'b0;
          pend_dn_nxt = 1'b0;
          case (action)
            ACT_MOVE: begin
              row_nxt  = row_moved;
              timer_en = 1'b1;
            end
            ACT_GOAL, ACT_WIN: begin
              // The turn continues from the bottom with a fresh timer;
              // a winning goal leaves the lanes as they are.
              row_nxt    = START_ROW;
              timer_load = 1'b1;
              if (state_q == QGAME_1) p1_nxt = score_inc;
              else                    p2_nxt = score_inc;
            end
            ACT_END_TURN: begin
              row_nxt    = START_ROW;
              timer_load = 1'b1;
              clear_nxt  = 1'b1;
            end
            default: ;
          endcase
        end else begin
          // Between ticks, remember any move request.
          pend_up_nxt = pend_up | btn_up;
          pend_dn_nxt = pend_dn | btn_down;
        end
      end

      QDONE: begin
        // Outputs frozen; only leaving the state moves the row.
        pend_up_nxt = 1'b0;
        pend_dn_nxt = 1'b0;
        if (!start) row_nxt = START_ROW;
      end

      default: ;
    endcase
  end

endmodule

// File: tb/tb_game_turn_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_turn_sequencer
//   Self-checking bench for game_turn_sequencer. A behavioural model of the
//   game rules (plain integers) predicts every output each cycle; directed
//   scenarios add hand-computed literal expectations, then a randomized
//   phase runs against the same model.
// -----------------------------------------------------------------------------
module tb_game_turn_sequencer;

  localparam int TT = 8;  // turn length used by this bench

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       hit = 1'b0;
  logic [1:0] state;
  logic [2:0] player_row;
  logic       lane_shift;
  logic       lane_clear;
  logic [3:0] p1_score;
  logic [3:0] p2_score;

  int n_checks = 0;
  int n_errors = 0;
  int shift_seen = 0;

  // Model state
  int m_state = 0;
  int m_row   = 7;
  int m_p1    = 0;
  int m_p2    = 0;
  int m_timer = TT;
  int m_pu    = 0;
  int m_pd    = 0;
  int m_shift = 0;
  int m_clear = 0;

  game_turn_sequencer #(
    .TURN_TICKS (TT),
    .TIMER_W    (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .tick       (tick),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .hit        (hit),
    .state      (state),
    .player_row (player_row),
    .lane_shift (lane_shift),
    .lane_clear (lane_clear),
    .p1_score   (p1_score),
    .p2_score   (p2_score)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_end_turn();
    m_row   = 7;
    m_timer = TT;
    m_clear = 1;
    m_state = (m_state == 1) ? 2 : 1;
  endtask

  // Game rules applied to the inputs present at a clock edge.
  task automatic model_step();
    int up, dn, target, sc;
    if (!reset) begin
      m_state = 0; m_row = 7; m_p1 = 0; m_p2 = 0; m_timer = TT;
      m_pu = 0; m_pd = 0; m_shift = 0; m_clear = 0;
      return;
    end
    m_shift = 0;
    m_clear = 0;
    if (m_state == 0) begin
      m_row = 7; m_pu = 0; m_pd = 0;
      if (start) begin
        m_state = 1; m_p1 = 0; m_p2 = 0; m_timer = TT; m_clear = 1;
      end
    end else if (m_state == 3) begin
      m_pu = 0; m_pd = 0;
      if (!start) begin
        m_state = 0; m_row = 7;
      end
    end else if (!start) begin
      m_state = 0; m_row = 7; m_pu = 0; m_pd = 0;
    end else if (tick) begin
      up = m_pu | int'(btn_up);
      dn = m_pd | int'(btn_down);
      m_pu = 0; m_pd = 0;
      m_shift = 1;
      if (hit) begin
        model_end_turn();
      end else begin
        target = m_row;
        if (up == 1 && dn == 0) target = m_row - 1;
        if (dn == 1 && up == 0) target = m_row + 1;
        if (target > 7) target = 7;
        if (target == 0) begin
          sc = (m_state == 1) ? m_p1 : m_p2;
          sc = (sc + 1 > 10) ? 10 : sc + 1;
          if (m_state == 1) m_p1 = sc; else m_p2 = sc;
          m_row = 7;
          m_timer = TT;
          if (sc == 10) m_state = 3;
        end else begin
          m_row = target;
          if (m_timer == 1) model_end_turn();
          else m_timer = m_timer - 1;
        end
      end
    end else begin
      m_pu = m_pu | int'(btn_up);
      m_pd = m_pd | int'(btn_down);
    end
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("state", state, m_state);
    check("player_row", player_row, m_row);
    check("p1_score", p1_score, m_p1);
    check("p2_score", p2_score, m_p2);
    check("lane_shift", lane_shift, m_shift);
    check("lane_clear", lane_clear, m_clear);
    if (lane_shift) shift_seen++;
  endtask

  task automatic tick_with(input logic u, input logic d, input logic h);
    tick = 1'b1; btn_up = u; btn_down = d; hit = h;
    cycle();
    tick = 1'b0; btn_up = 1'b0; btn_down = 1'b0; hit = 1'b0;
  endtask

  task automatic btn_then_tick(input logic u, input logic d);
    btn_up = u; btn_down = d;
    cycle();
    btn_up = 1'b0; btn_down = 1'b0;
    tick_with(1'b0, 1'b0, 1'b0);
  endtask

  task automatic climb_to_goal();
    for (int i = 0; i < 7; i++) btn_then_tick(1'b1, 1'b0);
  endtask

  initial begin
    // Reset and start
    reset = 1'b0; start = 1'b0;
    cycle();
    cycle();
    check("rst_state", state, 0);
    check("rst_row", player_row, 7);
    check("rst_scores", {p1_score, p2_score}, 0);
    check("rst_strobes", {lane_shift, lane_clear}, 0);
    reset = 1'b1; start = 1'b1;
    cycle();
    check("start_state", state, 1);
    check("start_clear", lane_clear, 1);
    cycle();
    check("start_clear_once", lane_clear, 0);

    // Climb to goal: rows 6..1 then a point for player 1
    shift_seen = 0;
    for (int i = 0; i < 7; i++) begin
      btn_then_tick(1'b1, 1'b0);
      if (i < 6) check("climb_row", player_row, 6 - i);
    end
    check("climb_p1", p1_score, 1);
    check("climb_row_reset", player_row, 7);
    check("climb_shifts", shift_seen, 7);

    // Collision at row 3, then a collision for player 2
    for (int i = 0; i < 4; i++) btn_then_tick(1'b1, 1'b0);
    check("pre_hit_row", player_row, 3);
    tick_with(1'b0, 1'b0, 1'b1);
    check("hit_state", state, 2);
    check("hit_row", player_row, 7);
    check("hit_clear", lane_clear, 1);
    check("hit_p1", p1_score, 1);
    tick_with(1'b0, 1'b0, 1'b1);
    check("hit2_state", state, 1);

    // Timeout: handoff on the TT-th idle tick
    for (int i = 0; i < TT; i++) begin
      tick_with(1'b0, 1'b0, 1'b0);
      if (i == TT - 2) check("timeout_not_yet", state, 1);
    end
    check("timeout_state", state, 2);
    check("timeout_clear", lane_clear, 1);

    // Goal on the final tick of player 2's turn beats the timeout
    tick_with(1'b0, 1'b0, 1'b0);
    climb_to_goal();
    check("goal_last_tick_p2", p2_score, 1);
    check("goal_last_tick_state", state, 2);
    check("goal_last_tick_clear", lane_clear, 0);

    // Clamp and simultaneous input
    btn_then_tick(1'b0, 1'b1);
    check("clamp_row", player_row, 7);
    btn_then_tick(1'b1, 1'b0);
    btn_up = 1'b1; cycle(); btn_up = 1'b0;
    btn_down = 1'b1; cycle(); btn_down = 1'b0;
    tick_with(1'b0, 1'b0, 1'b0);
    check("both_row", player_row, 6);
    tick_with(1'b1, 1'b0, 1'b0);
    check("same_cycle_row", player_row, 5);

    // Win for player 2 from a fresh turn
    tick_with(1'b0, 1'b0, 1'b1);
    tick_with(1'b0, 1'b0, 1'b1);
    for (int g = 0; g < 8; g++) climb_to_goal();
    check("p2_nine", p2_score, 9);
    climb_to_goal();
    check("win_p2", p2_score, 10);
    check("win_state", state, 3);
    check("win_clear", lane_clear, 0);
    shift_seen = 0;
    for (int i = 0; i < 3; i++) btn_then_tick(1'b1, 1'b0);
    check("done_no_shift", shift_seen, 0);
    check("done_row", player_row, 7);
    start = 1'b0;
    cycle();
    check("abort_state", state, 0);
    check("abort_p1", p1_score, 1);
    check("abort_p2", p2_score, 10);
    start = 1'b1;
    cycle();
    check("restart_scores", {p1_score, p2_score}, 0);

    // Randomized play against the model
    for (int i = 0; i < 4000; i++) begin
      reset    = ($urandom_range(0, 299) != 0);
      start    = ($urandom_range(0, 149) != 0);
      tick     = ($urandom_range(0, 2) == 0);
      btn_up   = ($urandom_range(0, 2) == 0);
      btn_down = ($urandom_range(0, 6) == 0);
      hit      = ($urandom_range(0, 13) == 0);
      cycle();
    end
    tick = 1'b0; btn_up = 1'b0; btn_down = 1'b0; hit = 1'b0;

    // Reset in the middle of a turn
    reset = 1'b1; start = 1'b1;
    cycle();
    cycle();
    tick_with(1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    btn_up = 1'b1;
    cycle();
    btn_up = 1'b0;
    check("midrst_state", state, 0);
    check("midrst_row", player_row, 7);
    check("midrst_scores", {p1_score, p2_score}, 0);
    check("midrst_strobes", {lane_shift, lane_clear}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
